// File: rtl/riscv_xc_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : riscv_xc_init_seq
// Description : Executes the XCrypto xc.init instruction by zeroing all
//               XCrypto registers through register-file write port W2.
//               Pipeline write-back traffic on W2 always passes through and
//               has priority. A stall (busy_o) is raised while clearing, and
//               a one-cycle done pulse follows the last clear write.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   init_req_i          xc.init request (level, held until acked)
//   init_ack_o          one-cycle acknowledge of init_req_i (IDLE only)
//   abort_i             pipeline flush, cancels an in-progress clear
//   busy_o              stall request while clearing
//   init_done_o         one-cycle pulse after all registers are cleared
//   *_b_pipe_i          pipeline W2 write request (address, data, enable)
//   *_b_o               W2 write request to the register file
// ============================================================================
module riscv_xc_init_seq #(
    parameter int ADDR_WIDTH   = 7,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_XC_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  init_req_i,
    output logic                  init_ack_o,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  init_done_o,

    input  logic [ADDR_WIDTH-1:0] waddr_b_pipe_i,
    input  logic [DATA_WIDTH-1:0] wdata_b_pipe_i,
    input  logic                  we_b_pipe_i,

    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,
    output logic                  we_b_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int IDX_W = (NUM_XC_WORDS > 1) ? $clog2(NUM_XC_WORDS) : 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_clear = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    // The top address bit selects the XCrypto bank; the register index
    // occupies the low bits (at most 5 bits, so bit 5 is always zero).
    localparam logic [ADDR_WIDTH-1:0] c_xc_base =
        {1'b1, {(ADDR_WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_XC_WORDS - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;

    logic [1:0]       w_state_next;
    logic [IDX_W-1:0] w_idx_next;

    // A sequencer write issues in CLEAR only when the pipeline leaves the
    // port free and no flush is cancelling the clear.
    logic             w_seq_wr;
    logic [ADDR_WIDTH-1:0] w_xc_addr;

    assign w_seq_wr  = (r_state == c_st_clear) && !abort_i && !we_b_pipe_i;
    assign w_xc_addr = c_xc_base | ADDR_WIDTH'(r_idx);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            c_st_idle: begin
                // abort_i has no effect here; a simultaneous request is taken.
                if (init_req_i) begin
                    w_state_next = c_st_clear;
                    w_idx_next   = '0;
                end
            end
            c_st_clear: begin
                if (abort_i) begin
                    w_state_next = c_st_idle;
                end else if (w_seq_wr) begin
                    // Pipeline contention simply holds idx, stretching CLEAR.
                    w_idx_next = r_idx + 1'b1;
                    if (r_idx == c_idx_last) begin
                        w_state_next = c_st_done;
                    end
                end
            end
            c_st_done: begin
                // Requests are ignored here; the next ack can come from IDLE.
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
                w_idx_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        // Pass-through by default, including while reset holds the FSM idle.
        waddr_b_o   = waddr_b_pipe_i;
        wdata_b_o   = wdata_b_pipe_i;
        we_b_o      = we_b_pipe_i;
        busy_o      = 1'b0;
        init_done_o = 1'b0;
        init_ack_o  = 1'b0;
        case (r_state)
            c_st_idle: begin
                init_ack_o = init_req_i;
            end
            c_st_clear: begin
                busy_o = 1'b1;
                if (w_seq_wr) begin
                    we_b_o    = 1'b1;
                    waddr_b_o = w_xc_addr;
                    wdata_b_o = '0;
                end
            end
            c_st_done: begin
                init_done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_xc_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_xc_init_seq
// Description : Directed self-checking bench for riscv_xc_init_seq.
//               Inputs change 1 time unit after the rising edge; outputs are
//               sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_xc_init_seq;

    logic        clk;
    logic        rst_n;
    logic        init_req_i;
    logic        init_ack_o;
    logic        abort_i;
    logic        busy_o;
    logic        init_done_o;
    logic [6:0]  waddr_b_pipe_i;
    logic [31:0] wdata_b_pipe_i;
    logic        we_b_pipe_i;
    logic [6:0]  waddr_b_o;
    logic [31:0] wdata_b_o;
    logic        we_b_o;

    int errors = 0;
    int checks = 0;

    riscv_xc_init_seq #(
        .ADDR_WIDTH   (7),
        .DATA_WIDTH   (32),
        .NUM_XC_WORDS (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .init_req_i     (init_req_i),
        .init_ack_o     (init_ack_o),
        .abort_i        (abort_i),
        .busy_o         (busy_o),
        .init_done_o    (init_done_o),
        .waddr_b_pipe_i (waddr_b_pipe_i),
        .wdata_b_pipe_i (wdata_b_pipe_i),
        .we_b_pipe_i    (we_b_pipe_i),
        .waddr_b_o      (waddr_b_o),
        .wdata_b_o      (wdata_b_o),
        .we_b_o         (we_b_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        init_req_i     = 1'b0;
        abort_i        = 1'b0;
        we_b_pipe_i    = 1'b0;
        waddr_b_pipe_i = 7'h00;
        wdata_b_pipe_i = 32'h0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        idle_inputs();
        rst_n          = 1'b0;
        we_b_pipe_i    = 1'b1;
        waddr_b_pipe_i = 7'h12;
        wdata_b_pipe_i = 32'h0000_1234;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b want 0", busy_o);
        end
        checks++;
        if (init_done_o !== 1'b0) begin
            errors++; $display("FAIL reset_done got %b want 0", init_done_o);
        end
        checks++;
        if (init_ack_o !== 1'b0) begin
            errors++; $display("FAIL reset_ack got %b want 0", init_ack_o);
        end
        checks++;
        if ({we_b_o, waddr_b_o, wdata_b_o} !== {1'b1, 7'h12, 32'h0000_1234}) begin
            errors++;
            $display("FAIL reset_passthru got we=%b a=%h d=%h want we=1 a=12 d=00001234",
                     we_b_o, waddr_b_o, wdata_b_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic_clear;
        init_req_i = 1'b1;
        @(negedge clk);
        checks++;
        if (init_ack_o !== 1'b1 || busy_o !== 1'b0 || we_b_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_c0 got ack=%b busy=%b we=%b want ack=1 busy=0 we=0",
                     init_ack_o, busy_o, we_b_o);
        end
        tick();
        init_req_i = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            checks++;
            if ({we_b_o, waddr_b_o, wdata_b_o, busy_o, init_done_o, init_ack_o} !==
                {1'b1, 7'h40 + 7'(c - 1), 32'h0, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL basic_write c%0d got we=%b a=%h d=%h busy=%b done=%b ack=%b want we=1 a=%h d=0 busy=1 done=0 ack=0",
                         c, we_b_o, waddr_b_o, wdata_b_o, busy_o, init_done_o, init_ack_o,
                         7'h40 + 7'(c - 1));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (init_done_o !== 1'b1 || busy_o !== 1'b0 || we_b_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_done c17 got done=%b busy=%b we=%b want done=1 busy=0 we=0",
                     init_done_o, busy_o, we_b_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (init_done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_c18 got done=%b busy=%b want done=0 busy=0",
                     init_done_o, busy_o);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_contention;
        logic [6:0] exp_a;
        init_req_i = 1'b1;
        tick();
        init_req_i = 1'b0;
        // Cycles 1..18: contention in cycle 3, clears 0x40..0x4F elsewhere.
        for (int c = 1; c <= 17; c++) begin
            if (c == 3) begin
                we_b_pipe_i    = 1'b1;
                waddr_b_pipe_i = 7'h05;
                wdata_b_pipe_i = 32'hDEAD_BEEF;
            end else begin
                idle_inputs();
            end
            exp_a = (c < 3) ? 7'h40 + 7'(c - 1) : 7'h40 + 7'(c - 2);
            @(negedge clk);
            checks++;
            if (c == 3) begin
                if ({we_b_o, waddr_b_o, wdata_b_o, busy_o} !==
                    {1'b1, 7'h05, 32'hDEAD_BEEF, 1'b1}) begin
                    errors++;
                    $display("FAIL cont_fwd got we=%b a=%h d=%h busy=%b want we=1 a=05 d=deadbeef busy=1",
                             we_b_o, waddr_b_o, wdata_b_o, busy_o);
                end
            end else if ({we_b_o, waddr_b_o, wdata_b_o, busy_o, init_done_o} !==
                         {1'b1, exp_a, 32'h0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL cont_write c%0d got we=%b a=%h d=%h busy=%b done=%b want we=1 a=%h d=0 busy=1 done=0",
                         c, we_b_o, waddr_b_o, wdata_b_o, busy_o, init_done_o, exp_a);
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (init_done_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL cont_done c18 got done=%b busy=%b want done=1 busy=0",
                     init_done_o, busy_o);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_abort;
        init_req_i = 1'b1;
        tick();
        init_req_i = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if ({we_b_o, waddr_b_o} !== {1'b1, 7'h40 + 7'(c - 1)}) begin
                errors++;
                $display("FAIL abort_write c%0d got we=%b a=%h want we=1 a=%h",
                         c, we_b_o, waddr_b_o, 7'h40 + 7'(c - 1));
            end
            tick();
        end
        abort_i = 1'b1;
        @(negedge clk);
        checks++;
        if (we_b_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_c6 got we=%b busy=%b want we=0 busy=1", we_b_o, busy_o);
        end
        tick();
        abort_i = 1'b0;
        for (int c = 7; c <= 20; c++) begin
            @(negedge clk);
            checks++;
            if ({busy_o, init_done_o, we_b_o} !== 3'b000) begin
                errors++;
                $display("FAIL abort_after c%0d got busy=%b done=%b we=%b want 0 0 0",
                         c, busy_o, init_done_o, we_b_o);
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_req_held;
        logic exp_ack;
        init_req_i = 1'b1;
        for (int c = 0; c <= 18; c++) begin
            exp_ack = (c == 0) || (c == 18);
            @(negedge clk);
            checks++;
            if (init_ack_o !== exp_ack) begin
                errors++;
                $display("FAIL held_ack c%0d got %b want %b", c, init_ack_o, exp_ack);
            end
            if (c == 17) begin
                checks++;
                if (init_done_o !== 1'b1) begin
                    errors++;
                    $display("FAIL held_done c17 got %b want 1", init_done_o);
                end
            end
            tick();
        end
        // Second clear was accepted in cycle 18; cancel it.
        init_req_i = 1'b0;
        abort_i    = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL held_second_busy got %b want 1", busy_o);
        end
        tick();
        abort_i = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL held_idle_busy got %b want 0", busy_o);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_clear;
        init_req_i = 1'b1;
        tick();
        init_req_i = 1'b0;
        for (int c = 1; c <= 9; c++) tick();
        @(negedge clk);
        checks++;
        if ({we_b_o, waddr_b_o, busy_o} !== {1'b1, 7'h49, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_pre got we=%b a=%h busy=%b want we=1 a=49 busy=1",
                     we_b_o, waddr_b_o, busy_o);
        end
        #1;
        we_b_pipe_i    = 1'b1;
        waddr_b_pipe_i = 7'h33;
        wdata_b_pipe_i = 32'hCAFE_F00D;
        rst_n          = 1'b0;
        #1;
        checks++;
        if ({busy_o, we_b_o, waddr_b_o, wdata_b_o} !==
            {1'b0, 1'b1, 7'h33, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL rstmid_async got busy=%b we=%b a=%h d=%h want busy=0 we=1 a=33 d=cafef00d",
                     busy_o, we_b_o, waddr_b_o, wdata_b_o);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        tick();
        // Fresh clear must start from idx 0 and run the full length.
        init_req_i = 1'b1;
        @(negedge clk);
        checks++;
        if (init_ack_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle got ack=%b busy=%b want ack=1 busy=0",
                     init_ack_o, busy_o);
        end
        tick();
        init_req_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({we_b_o, waddr_b_o, wdata_b_o} !== {1'b1, 7'h40, 32'h0}) begin
            errors++;
            $display("FAIL rstmid_idx0 got we=%b a=%h d=%h want we=1 a=40 d=0",
                     we_b_o, waddr_b_o, wdata_b_o);
        end
        for (int c = 1; c <= 16; c++) tick();
        @(negedge clk);
        checks++;
        if (init_done_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_done got %b want 1", init_done_o);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_passthrough;
        logic        r_we;
        logic [6:0]  r_a;
        logic [31:0] r_d;
        idle_inputs();
        for (int c = 0; c < 100; c++) begin
            r_we = 1'($urandom_range(0, 1));
            r_a  = 7'($urandom);
            r_d  = $urandom;
            we_b_pipe_i    = r_we;
            waddr_b_pipe_i = r_a;
            wdata_b_pipe_i = r_d;
            @(negedge clk);
            checks++;
            if ({we_b_o, waddr_b_o, wdata_b_o, busy_o} !== {r_we, r_a, r_d, 1'b0}) begin
                errors++;
                $display("FAIL passthru c%0d got we=%b a=%h d=%h busy=%b want we=%b a=%h d=%h busy=0",
                         c, we_b_o, waddr_b_o, wdata_b_o, busy_o, r_we, r_a, r_d);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_basic_clear();
        test_contention();
        test_abort();
        test_req_held();
        test_reset_mid_clear();
        test_passthrough();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
